// File: rtl/deser_fifo.sv
`default_nettype none
// ============================================================================
// Module      : deser_fifo
// Description : Serial-to-parallel receiver feeding a synchronous word queue.
//               Bits strobed in on write_in are assembled into WIDTH-bit
//               words (LSB- or MSB-first) and pushed into a DEPTH-entry queue
//               that the consumer pops with dequeue_in. Sticky overflow and
//               underflow flags, occupancy count and synchronous flush.
//               Optional feature macro: DESER_FIFO_PARITY_EN adds a trailing
//               even-parity bit per frame and a sticky parity_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module deser_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_in,
  input  logic                     write_in,
  input  logic                     dequeue_in,
  input  logic                     flush_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
`ifdef DESER_FIFO_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
`ifdef DESER_FIFO_PARITY_EN
  localparam int c_LAST = WIDTH;        // data bits 0..WIDTH-1, parity at WIDTH
`else
  localparam int c_LAST = WIDTH - 1;
`endif
  localparam int              c_BCW      = $clog2(c_LAST + 1);
  localparam logic [c_BCW-1:0] c_LAST_CNT = c_BCW'(c_LAST);
  localparam logic [c_CW-1:0]  c_FULL     = c_CW'(DEPTH);

  // Registered state and next-state
  logic [WIDTH-1:0] shift_q,    shift_d;
  logic [c_BCW-1:0] bit_cnt_q,  bit_cnt_d;
  logic [c_AW-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [c_AW-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [c_CW-1:0]  count_q,    count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q,    valid_d;
  logic             ovf_q,      ovf_d;
  logic             udf_q,      udf_d;
  logic             empty_q;
  logic             full_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Combinational helpers
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_last;
  logic             w_shift_en;
  logic             w_word_ok;
  logic [WIDTH-1:0] w_word;
  logic             w_pop;
  logic             w_push;

  // Shift direction chosen at elaboration time
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shift_nxt = {shift_q[WIDTH-2:0], data_in};
    end else begin : g_lsb_first
      assign w_shift_nxt = {data_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (bit_cnt_q == c_LAST_CNT);

`ifdef DESER_FIFO_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  logic w_par_bad;

  // Parity bit is not shifted in: the data word is already complete in shift_q
  assign w_shift_en = write_in & ~w_last;
  assign w_par_bad  = par_q ^ data_in;
  assign w_word_ok  = write_in & w_last & ~w_par_bad;
  assign w_word     = shift_q;
  assign parity_err = perr_q;
`else
  assign w_shift_en = write_in;
  assign w_word_ok  = write_in & w_last;
  assign w_word     = w_shift_nxt;     // includes the bit captured this edge
`endif

  // A pop on a full queue frees the slot the simultaneous push needs
  assign w_pop  = ~flush_in & dequeue_in & (count_q != '0);
  assign w_push = ~flush_in & w_word_ok & ((count_q != c_FULL) | w_pop);

  // Next-state logic; flush overrides every other request
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
`ifdef DESER_FIFO_PARITY_EN
    par_d      = par_q;
    perr_d     = perr_q;
`endif
    if (flush_in) begin
      shift_d    = '0;
      bit_cnt_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      data_out_d = '0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
`ifdef DESER_FIFO_PARITY_EN
      par_d      = 1'b0;
      perr_d     = 1'b0;
`endif
    end else begin
      if (w_shift_en) begin
        shift_d = w_shift_nxt;
      end
      if (write_in) begin
        bit_cnt_d = w_last ? '0 : bit_cnt_q + c_BCW'(1);
      end
`ifdef DESER_FIFO_PARITY_EN
      if (write_in) begin
        par_d = w_last ? 1'b0 : (par_q ^ data_in);
        if (w_last && w_par_bad) begin
          perr_d = 1'b1;
        end
      end
`endif
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + c_AW'(1);
      end
      if (w_pop) begin
        rd_ptr_d   = rd_ptr_q + c_AW'(1);
        data_out_d = mem_q[rd_ptr_q];
        valid_d    = 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + c_CW'(1);
        2'b01:   count_d = count_q - c_CW'(1);
        default: count_d = count_q;
      endcase
      if (w_word_ok && !w_push) begin
        ovf_d = 1'b1;
      end
      if (dequeue_in && (count_q == '0)) begin
        udf_d = 1'b1;
      end
    end
  end

  // Control and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
`ifdef DESER_FIFO_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == c_FULL);
`ifdef DESER_FIFO_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  // Queue storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_word;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_deser_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_deser_fifo
// Description : Scoreboard bench for deser_fifo. Two instances share stimulus:
//               one LSB-first, one MSB-first. Expected popped words are queued
//               when a pop is issued; a monitor compares on valid_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deser_fifo;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         data_in = 1'b0;
  logic         write_in = 1'b0;
  logic         dequeue_in = 1'b0;
  logic         flush_in = 1'b0;

  logic [W-1:0] dout_l, dout_m;
  logic         vld_l, vld_m;
  logic [2:0]   cnt_l, cnt_m;
  logic         emp_l, emp_m, ful_l, ful_m, ovf_l, ovf_m, udf_l, udf_m;
`ifdef DESER_FIFO_PARITY_EN
  logic         perr_l, perr_m;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_l[$];
  logic [W-1:0] exp_m[$];

  always #5 clk = ~clk;

  deser_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .write_in(write_in),
    .dequeue_in(dequeue_in), .flush_in(flush_in), .data_out(dout_l),
    .valid_out(vld_l), .count(cnt_l), .empty(emp_l), .full(ful_l),
    .overflow(ovf_l), .underflow(udf_l)
`ifdef DESER_FIFO_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

  deser_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .write_in(write_in),
    .dequeue_in(dequeue_in), .flush_in(flush_in), .data_out(dout_m),
    .valid_out(vld_m), .count(cnt_m), .empty(emp_m), .full(ful_m),
    .overflow(ovf_m), .underflow(udf_m)
`ifdef DESER_FIFO_PARITY_EN
    , .parity_err(perr_m)
`endif
  );

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    data_in  = b;
    write_in = 1'b1;
    step();
    write_in = 1'b0;
  endtask

  // Expectation pushed for both instances; LSB word bit order is the send order
  task automatic expect_word(input logic [W-1:0] w);
    exp_l.push_back(w);
    exp_m.push_back(rev(w));
  endtask

  task automatic pop();
    dequeue_in = 1'b1;
    step();
    dequeue_in = 1'b0;
  endtask

  // Full frame back-to-back, optionally with a pop on the final edge
  task automatic send_frame(input logic [W-1:0] w, input logic dq_last);
    for (int i = 0; i < W; i++) begin
      data_in  = w[i];
      write_in = 1'b1;
`ifndef DESER_FIFO_PARITY_EN
      if (i == W - 1) dequeue_in = dq_last;
`endif
      step();
    end
`ifdef DESER_FIFO_PARITY_EN
    data_in    = ^w;
    dequeue_in = dq_last;
    step();
`endif
    write_in   = 1'b0;
    dequeue_in = 1'b0;
  endtask

  // Scoreboard monitor: compare every presented word against the queue head
  always @(negedge clk) begin
    if (rst_n && vld_l) begin
      checks++;
      if (exp_l.size() == 0) begin
        errors++;
        $display("FAIL pop_lsb_unexpected actual=%0h required=none", dout_l);
      end else begin
        logic [W-1:0] e;
        e = exp_l.pop_front();
        if (dout_l !== e) begin
          errors++;
          $display("FAIL pop_lsb actual=%0h required=%0h", dout_l, e);
        end
      end
    end
    if (rst_n && vld_m) begin
      checks++;
      if (exp_m.size() == 0) begin
        errors++;
        $display("FAIL pop_msb_unexpected actual=%0h required=none", dout_m);
      end else begin
        logic [W-1:0] e;
        e = exp_m.pop_front();
        if (dout_m !== e) begin
          errors++;
          $display("FAIL pop_msb actual=%0h required=%0h", dout_m, e);
        end
      end
    end
  end

  logic [W-1:0] bits5;

  initial begin
    // Reset state
    step(); step();
    chk("rst_count", 32'(cnt_l), 0);
    chk("rst_empty", 32'(emp_l), 1);
    chk("rst_full", 32'(ful_l), 0);
    chk("rst_flags", {30'd0, ovf_l, udf_l}, 0);
    chk("rst_valid", 32'(vld_l), 0);
    chk("rst_dout", 32'(dout_l), 0);
    rst_n = 1'b1;
    step();

    // Eight 1-bits: counted on the 8th data edge
    for (int i = 0; i < W - 1; i++) send_bit(1'b1);
    chk("ff_count_before_last", 32'(cnt_l), 0);
    send_bit(1'b1);
`ifdef DESER_FIFO_PARITY_EN
    send_bit(1'b0);
`endif
    chk("ff_count", 32'(cnt_l), 1);
    chk("ff_empty", 32'(emp_l), 0);
    expect_word(8'hFF);
    pop();
    chk("ff_valid", 32'(vld_l), 1);
    chk("ff_empty_after_pop", 32'(emp_l), 1);
    step();
    chk("ff_valid_pulse", 32'(vld_l), 0);

    // 1,0,1,0,0,0,0,0 with idle gaps: 0x05 LSB-first, 0xA0 MSB-first
    bits5 = 8'h05;
    for (int i = 0; i < W; i++) begin
      send_bit(bits5[i]);
      step();
    end
`ifdef DESER_FIFO_PARITY_EN
    send_bit(1'b0);
`endif
    chk("gap_count", 32'(cnt_l), 1);
    exp_l.push_back(8'h05);
    exp_m.push_back(8'hA0);
    pop();
    step();

    // Fill, overflow, drain, underflow
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    send_frame(8'h33, 1'b0);
    send_frame(8'h44, 1'b0);
    chk("fill_full", 32'(ful_l), 1);
    chk("fill_count", 32'(cnt_l), 4);
    chk("fill_no_ovf", 32'(ovf_l), 0);
    send_frame(8'h55, 1'b0);
    chk("ovf_flag", 32'(ovf_l), 1);
    chk("ovf_count", 32'(cnt_l), 4);
    expect_word(8'h11); pop();
    expect_word(8'h22); pop();
    expect_word(8'h33); pop();
    expect_word(8'h44); pop();
    chk("drain_empty", 32'(emp_l), 1);
    chk("drain_no_udf", 32'(udf_l), 0);
    pop();
    chk("udf_flag", 32'(udf_l), 1);
    chk("udf_valid", 32'(vld_l), 0);
    chk("udf_hold_lsb", 32'(dout_l), 32'h44);
    chk("udf_hold_msb", 32'(dout_m), 32'h22);
    chk("ovf_sticky", 32'(ovf_l), 1);

    // Flush clears flags and output word
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    chk("flush_flags", {30'd0, ovf_l, udf_l}, 0);
    chk("flush_dout", 32'(dout_l), 0);

    // Full queue with push and pop on the same edge
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    send_frame(8'h33, 1'b0);
    send_frame(8'h44, 1'b0);
    expect_word(8'h11);
    send_frame(8'h66, 1'b1);
    chk("simul_full_count", 32'(cnt_l), 4);
    chk("simul_full_ovf", 32'(ovf_l), 0);
    chk("simul_full_valid", 32'(vld_l), 1);
    expect_word(8'h22); pop();
    expect_word(8'h33); pop();
    expect_word(8'h44); pop();
    expect_word(8'h66); pop();
    chk("simul_full_empty", 32'(emp_l), 1);

    // Empty queue with push and pop on the same edge
    send_frame(8'h5A, 1'b1);
    chk("simul_empty_count", 32'(cnt_l), 1);
    chk("simul_empty_udf", 32'(udf_l), 1);
    chk("simul_empty_valid", 32'(vld_l), 0);
    expect_word(8'h5A); pop();

    // Reset in the middle of a word
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", 32'(dout_l), 0);
    chk("midrst_flags", {30'd0, ovf_l, udf_l}, 0);
    chk("midrst_empty", 32'(emp_l), 1);
    step();
    rst_n = 1'b1;
    send_frame(8'hC3, 1'b0);
    chk("midrst_count", 32'(cnt_l), 1);
    expect_word(8'hC3); pop();

    // Flush with two words queued and a partial word pending
    pop();
    send_frame(8'h12, 1'b0);
    send_frame(8'h34, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    chk("preflush_count", 32'(cnt_l), 2);
    chk("preflush_udf", 32'(udf_l), 1);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    chk("flush_count", 32'(cnt_l), 0);
    chk("flush_empty", 32'(emp_l), 1);
    chk("flush_udf", 32'(udf_l), 0);
    send_frame(8'h81, 1'b0);
    expect_word(8'h81); pop();

`ifdef DESER_FIFO_PARITY_EN
    // Bad parity frame is dropped, good one is queued
    for (int i = 0; i < W; i++) send_bit(i < 2);
    send_bit(1'b1);
    chk("par_err", 32'(perr_l), 1);
    chk("par_err_count", 32'(cnt_l), 0);
    for (int i = 0; i < W; i++) send_bit(i < 2);
    send_bit(1'b0);
    chk("par_ok_count", 32'(cnt_l), 1);
    expect_word(8'h03); pop();
`endif

    step(); step();
    chk("sb_lsb_drained", exp_l.size(), 0);
    chk("sb_msb_drained", exp_m.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
